// File: rtl/parking_pkg.sv
// Shared parking-lot definitions: gate state encoding, default gate codes
// and a small helper used to size shared timers.
package parking_pkg;

  localparam int PSWD_W = 8;

  localparam logic [PSWD_W-1:0] ENTRY_CODE = 8'd253;
  localparam logic [PSWD_W-1:0] EXIT_CODE  = 8'd194;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_CODE = 2'd1,
    OPEN      = 2'd2,
    LOCKED    = 2'd3
  } park_state_t;

  // Largest of three cycle counts, used to size one timer shared by all states.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/exit_gate_ctrl_gate_timer.sv
// gate_timer: loadable, saturating down-counter. done is high while the
// count sits at zero; loading N-1 makes done rise in the N-th cycle after load.
module gate_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_reg;

  // Load on request, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/exit_gate_ctrl.sv
// exit_gate_ctrl: exit barrier controller. A car at the front sensor enters
// code entry; the correct exit code opens the gate, which closes once the
// back sensor confirms passage (with a one-cycle exit_pulse) or after a
// gate-open timeout. Code entry is abandoned on car drop or timeout.
// Optional macro EXIT_ALARM_EN: counts wrong codes and enters a timed
// LOCKED state with alarm raised after MAX_TRIES wrong codes.
module exit_gate_ctrl #(
  parameter int                PSWD_W    = parking_pkg::PSWD_W,
  parameter logic [PSWD_W-1:0] EXIT_CODE = parking_pkg::EXIT_CODE,
  parameter int                CODE_TO   = 16,
  parameter int                OPEN_TO   = 32,
  parameter int                MAX_TRIES = 3,
  parameter int                LOCK_CYC  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              car,
  input  logic              fr_sens,
  input  logic              bk_sens,
  input  logic [PSWD_W-1:0] pswd,
  input  logic              pswd_vld,
  output logic              gate,
  output logic              exit_pulse,
  output logic              alarm
);

  import parking_pkg::*;

  localparam int TMR_MAX = max3(CODE_TO, OPEN_TO, LOCK_CYC);
  localparam int TMR_W   = ($clog2(TMR_MAX) > 0) ? $clog2(TMR_MAX) : 1;

  // Timer load values: done rises when a state has lasted its full budget.
  localparam logic [TMR_W-1:0] CODE_LD = TMR_W'(CODE_TO - 1);
  localparam logic [TMR_W-1:0] OPEN_LD = TMR_W'(OPEN_TO - 1);
  localparam logic [TMR_W-1:0] LOCK_LD = TMR_W'(LOCK_CYC - 1);

  park_state_t      state_reg, state_next;
  logic             gate_reg, gate_next;
  logic             exit_pulse_reg, exit_pulse_next;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_done;
  logic             code_ok;

  assign code_ok = pswd_vld && (pswd == EXIT_CODE);

`ifdef EXIT_ALARM_EN
  localparam int TRY_W = ($clog2(MAX_TRIES + 1) > 0) ? $clog2(MAX_TRIES + 1) : 1;
  localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);

  logic [TRY_W-1:0] tries_reg, tries_next;
  logic             alarm_reg, alarm_next;
`else
  // The wrong-code limit only matters when the lockout is built.
  logic unused_cfg;
  assign unused_cfg = (MAX_TRIES > 0);
`endif

  gate_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .done     (tmr_done)
  );

  // Next-state, timer reload and next-output decisions.
  always_comb begin
    state_next      = state_reg;
    exit_pulse_next = 1'b0;
    tmr_load        = 1'b0;
    tmr_load_val    = '0;
`ifdef EXIT_ALARM_EN
    tries_next      = tries_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (car && fr_sens) state_next = WAIT_CODE;
      end

      WAIT_CODE: begin
        if (code_ok) begin
          state_next = OPEN;
`ifdef EXIT_ALARM_EN
          tries_next = '0;
`endif
        end else if (!car) begin
          state_next = IDLE;
        end else if (tmr_done) begin
          state_next = IDLE;
        end else if (pswd_vld) begin
`ifdef EXIT_ALARM_EN
          tries_next = (tries_reg == TRIES_MAX) ? TRIES_MAX : tries_reg + 1'b1;
          if (tries_next == TRIES_MAX) state_next = LOCKED;
`else
          // Without lockout a wrong code just keeps the gate waiting.
          state_next = WAIT_CODE;
`endif
        end
      end

      OPEN: begin
        // The car may already be under the barrier, so car is not consulted.
        if (bk_sens) begin
          state_next      = IDLE;
          exit_pulse_next = 1'b1;
        end else if (tmr_done) begin
          state_next = IDLE;
        end
      end

      LOCKED: begin
`ifdef EXIT_ALARM_EN
        if (tmr_done) begin
          state_next = IDLE;
          tries_next = '0;
        end
`else
        state_next = IDLE;
`endif
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Every state entry restarts the timer with that state's budget.
    if (state_next != state_reg) begin
      tmr_load = 1'b1;
      case (state_next)
        WAIT_CODE: tmr_load_val = CODE_LD;
        OPEN:      tmr_load_val = OPEN_LD;
        LOCKED:    tmr_load_val = LOCK_LD;
        default:   tmr_load_val = '0;
      endcase
    end

    gate_next = (state_next == OPEN);
`ifdef EXIT_ALARM_EN
    alarm_next = (state_next == LOCKED);
`endif
  end

  // State and registered outputs; reset closes the gate on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      gate_reg       <= 1'b0;
      exit_pulse_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      gate_reg       <= gate_next;
      exit_pulse_reg <= exit_pulse_next;
    end
  end

`ifdef EXIT_ALARM_EN
  // Wrong-code counter and alarm output.
  always_ff @(posedge clk) begin
    if (rst) begin
      tries_reg <= '0;
      alarm_reg <= 1'b0;
    end else begin
      tries_reg <= tries_next;
      alarm_reg <= alarm_next;
    end
  end

  assign alarm = alarm_reg;
`else
  assign alarm = 1'b0;
`endif

  assign gate       = gate_reg;
  assign exit_pulse = exit_pulse_reg;

endmodule

// File: tb/tb_exit_gate_ctrl.sv
// Testbench for exit_gate_ctrl: directed stimulus, a cycle-stamped phase
// model of the exit gate rules compared every cycle, plus literal checks.
// Honours EXIT_ALARM_EN the same way the design does.
`timescale 1ns/1ps
module tb_exit_gate_ctrl;

  localparam int         CODE_TO   = 16;
  localparam int         OPEN_TO   = 32;
  localparam int         LOCK_CYC  = 64;
  localparam int         MAX_TRIES = 3;
  localparam logic [7:0] GOOD      = 8'd194;
  localparam logic [7:0] BAD       = 8'd255;
`ifdef EXIT_ALARM_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, car, fr_sens, bk_sens, pswd_vld;
  logic [7:0] pswd;
  logic       gate, exit_pulse, alarm;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b1;

  always #5 clk = ~clk;

  exit_gate_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .car        (car),
    .fr_sens    (fr_sens),
    .bk_sens    (bk_sens),
    .pswd       (pswd),
    .pswd_vld   (pswd_vld),
    .gate       (gate),
    .exit_pulse (exit_pulse),
    .alarm      (alarm)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: phase 0 idle, 1 code entry, 2 open, 3 locked. Time spent in a
  // phase is the distance between the global cycle number and the cycle
  // the phase was entered.
  int cyc      = 0;
  int m_phase  = 0;
  int m_enter  = 0;
  int m_wrong  = 0;
  bit m_gate   = 1'b0;
  bit m_pulse  = 1'b0;
  bit m_alarm  = 1'b0;

  always @(posedge clk) begin
    int np, nw, age;
    bit pul;
    np  = m_phase;
    nw  = m_wrong;
    pul = 1'b0;
    age = cyc - m_enter;
    if (rst) begin
      np = 0;
      nw = 0;
    end else begin
      case (m_phase)
        0: if (car && fr_sens) np = 1;
        1: begin
          if (pswd_vld && pswd == GOOD) begin
            np = 2;
            nw = 0;
          end else if (!car) np = 0;
          else if (age >= CODE_TO - 1) np = 0;
          else if (pswd_vld && ALARM_EN) begin
            nw = (m_wrong < MAX_TRIES) ? m_wrong + 1 : MAX_TRIES;
            if (nw == MAX_TRIES) np = 3;
          end
        end
        2: begin
          if (bk_sens) begin
            np  = 0;
            pul = 1'b1;
          end else if (age >= OPEN_TO - 1) np = 0;
        end
        3: begin
          if (age >= LOCK_CYC - 1) begin
            np = 0;
            nw = 0;
          end
        end
        default: np = 0;
      endcase
    end
    if (np != m_phase || rst) m_enter <= cyc + 1;
    m_phase <= np;
    m_wrong <= nw;
    m_gate  <= (np == 2);
    m_pulse <= pul;
    m_alarm <= (np == 3);
    cyc     <= cyc + 1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("gate", gate, m_gate);
      chk("exit_pulse", exit_pulse, m_pulse);
      chk("alarm", alarm, m_alarm);
    end
  end

  initial begin
    int cnt, cnt2;
    rst = 1'b1; car = 1'b1; fr_sens = 1'b1; bk_sens = 1'b0;
    pswd = '0; pswd_vld = 1'b0;

    // Reset held two cycles with a car at the sensor.
    tick(1);
    chk("rst_gate", gate, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_pulse", exit_pulse, 0);
    tick(1);
    chk("rst2_gate", gate, 0);
    rst = 1'b0; car = 1'b0; fr_sens = 1'b0;
    tick(2);
    chk("idle_gate", gate, 0);

    // Normal exit.
    car = 1'b1; fr_sens = 1'b1; tick(1); fr_sens = 1'b0;
    chk("wait_gate_closed", gate, 0);
    pswd = GOOD; pswd_vld = 1'b1; tick(1); pswd_vld = 1'b0; pswd = '0;
    chk("open_gate", gate, 1);
    tick(1);
    bk_sens = 1'b1; tick(1); bk_sens = 1'b0; car = 1'b0;
    chk("pass_gate", gate, 0);
    chk("pass_pulse", exit_pulse, 1);
    tick(1);
    chk("pulse_once", exit_pulse, 0);
    tick(1);

    // Three wrong codes.
    car = 1'b1; fr_sens = 1'b1; tick(1); fr_sens = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pswd = BAD; pswd_vld = 1'b1; tick(1); pswd_vld = 1'b0;
      if (k < 2) tick(1);
    end
`ifdef EXIT_ALARM_EN
    chk("lock_alarm_on", alarm, 1);
    cnt = 1; cnt2 = 0;
    for (int i = 0; i < 80; i++) begin
      if (i == 3) begin pswd = GOOD; pswd_vld = 1'b1; end
      else pswd_vld = 1'b0;
      tick(1);
      if (alarm) cnt++;
      if (gate) cnt2++;
    end
    chk("lock_len", cnt, 64);
    chk("lock_gate_closed", cnt2, 0);
    chk("lock_release", alarm, 0);
`else
    chk("no_alarm", alarm, 0);
    pswd = GOOD; pswd_vld = 1'b1; tick(1); pswd_vld = 1'b0;
    chk("still_waiting_opens", gate, 1);
    bk_sens = 1'b1; tick(1); bk_sens = 1'b0;
`endif
    car = 1'b0; tick(2);

    // Correct code in the last code-entry cycle wins over the timeout.
    car = 1'b1; fr_sens = 1'b1; tick(1); fr_sens = 1'b0;
    tick(CODE_TO - 1);
    pswd = GOOD; pswd_vld = 1'b1; tick(1); pswd_vld = 1'b0;
    chk("code_at_last_wait_cycle", gate, 1);
    bk_sens = 1'b1; tick(1); bk_sens = 1'b0; car = 1'b0; tick(2);

    // Code one cycle after the timeout is ignored.
    car = 1'b1; fr_sens = 1'b1; tick(1); fr_sens = 1'b0;
    tick(CODE_TO);
    pswd = GOOD; pswd_vld = 1'b1; tick(1); pswd_vld = 1'b0;
    chk("code_after_timeout", gate, 0);
    car = 1'b0; tick(2);

    // Correct code beats a simultaneous car drop.
    car = 1'b1; fr_sens = 1'b1; tick(1); fr_sens = 1'b0;
    car = 1'b0; pswd = GOOD; pswd_vld = 1'b1; tick(1); pswd_vld = 1'b0;
    chk("code_beats_car_drop", gate, 1);
    bk_sens = 1'b1; tick(1); bk_sens = 1'b0; tick(1);

    // Car drop abandons code entry.
    car = 1'b1; fr_sens = 1'b1; tick(1); fr_sens = 1'b0;
    car = 1'b0; tick(1);
    car = 1'b1; pswd = GOOD; pswd_vld = 1'b1; tick(1); pswd_vld = 1'b0;
    chk("code_after_car_drop", gate, 0);
    car = 1'b0; tick(2);

    // Gate-open timeout with no back sensor.
    car = 1'b1; fr_sens = 1'b1; tick(1); fr_sens = 1'b0;
    pswd = GOOD; pswd_vld = 1'b1; tick(1); pswd_vld = 1'b0; car = 1'b0;
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 40; i++) begin
      if (gate) cnt++;
      if (exit_pulse) cnt2++;
      tick(1);
    end
    chk("open_timeout_len", cnt, 32);
    chk("open_timeout_pulse", cnt2, 0);

    // Back sensor in the final open cycle beats the timeout.
    car = 1'b1; fr_sens = 1'b1; tick(1); fr_sens = 1'b0;
    pswd = GOOD; pswd_vld = 1'b1; tick(1); pswd_vld = 1'b0; car = 1'b0;
    tick(OPEN_TO - 1);
    chk("open_t31_gate", gate, 1);
    bk_sens = 1'b1; tick(1); bk_sens = 1'b0;
    chk("t31_pulse", exit_pulse, 1);
    chk("t31_gate", gate, 0);
    tick(2);

    // Reset in the middle of OPEN closes the gate with no pulse.
    car = 1'b1; fr_sens = 1'b1; tick(1); fr_sens = 1'b0;
    pswd = GOOD; pswd_vld = 1'b1; tick(1); pswd_vld = 1'b0;
    tick(5);
    rst = 1'b1; bk_sens = 1'b1; tick(1); rst = 1'b0; bk_sens = 1'b0;
    chk("rst_open_gate", gate, 0);
    chk("rst_open_pulse", exit_pulse, 0);
    car = 1'b0; tick(3);

    cmp_en = 1'b0;
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
